// File: rtl/gate_ctrl.sv
// rtl/gate_ctrl.sv - equal-precision gate sequencer; optional timeout path via GATE_CTRL_TIMEOUT_EN
`timescale 1ns/1ps

module gate_ctrl #(
  parameter int GATE_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start_sig,
  input  logic fx,
  output logic gate,
  output logic cnt_clr,
  output logic cnt_latch,
  output logic busy,
  output logic valid,
  output logic done,
  output logic timeout
);

  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
`ifdef GATE_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ARM,
    S_GATE,
    S_LATCH,
    S_FIN
  } state_t;

  logic [SYNC_STAGES-1:0] r_start_sync;
  logic [SYNC_STAGES-1:0] r_fx_sync;
  logic                   r_start_d;
  logic                   r_fx_d;
  logic                   r_start_rise;
  logic                   r_fx_rise;

  state_t                 r_state;
  logic                   r_gate;
  logic                   r_cnt_clr;
  logic                   r_cnt_latch;
  logic                   r_valid;
  logic                   r_done;
  logic [GW-1:0]          r_preset;
  logic                   r_preset_done;
`ifdef GATE_CTRL_TIMEOUT_EN
  logic [TW-1:0]          r_tcnt;
  logic                   r_timeout;
`else
  logic                   w_unused_timeout_cfg;
`endif

  // Synchronize the async inputs, then register a one-cycle pulse per rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_sync <= '0;
      r_fx_sync    <= '0;
      r_start_d    <= 1'b0;
      r_fx_d       <= 1'b0;
      r_start_rise <= 1'b0;
      r_fx_rise    <= 1'b0;
    end else begin
      r_start_sync <= {r_start_sync[SYNC_STAGES-2:0], start_sig};
      r_fx_sync    <= {r_fx_sync[SYNC_STAGES-2:0], fx};
      r_start_d    <= r_start_sync[SYNC_STAGES-1];
      r_fx_d       <= r_fx_sync[SYNC_STAGES-1];
      r_start_rise <= r_start_sync[SYNC_STAGES-1] & ~r_start_d;
      r_fx_rise    <= r_fx_sync[SYNC_STAGES-1] & ~r_fx_d;
    end
  end

  // Measurement sequencer: gate, pulses and flags are registered with the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_gate        <= 1'b0;
      r_cnt_clr     <= 1'b0;
      r_cnt_latch   <= 1'b0;
      r_valid       <= 1'b0;
      r_done        <= 1'b0;
      r_preset      <= '0;
      r_preset_done <= 1'b0;
`ifdef GATE_CTRL_TIMEOUT_EN
      r_tcnt        <= '0;
      r_timeout     <= 1'b0;
`endif
    end else begin
      r_cnt_clr   <= 1'b0;
      r_cnt_latch <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_start_rise) begin
            r_valid <= 1'b0;
`ifdef GATE_CTRL_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_cnt_clr <= 1'b1;
`ifdef GATE_CTRL_TIMEOUT_EN
          r_tcnt <= '0;
`endif
          r_state <= S_ARM;
        end
        S_ARM: begin
          // An fx edge on the terminal timeout cycle still opens the gate
          if (r_fx_rise) begin
            r_gate        <= 1'b1;
            r_preset      <= '0;
            r_preset_done <= 1'b0;
            r_state       <= S_GATE;
          end
`ifdef GATE_CTRL_TIMEOUT_EN
          else if (r_tcnt == TO_LAST) begin
            r_gate    <= 1'b0;
            r_timeout <= 1'b1;
            r_valid   <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
`endif
        end
        S_GATE: begin
          if (r_preset != GATE_LAST) begin
            r_preset <= r_preset + GW'(1);
          end
          // Close only on an fx edge once the preset time has elapsed
          if (r_fx_rise && r_preset_done) begin
            r_gate  <= 1'b0;
            r_state <= S_LATCH;
          end
`ifdef GATE_CTRL_TIMEOUT_EN
          else if (r_preset_done && (r_tcnt == TO_LAST)) begin
            r_gate    <= 1'b0;
            r_timeout <= 1'b1;
            r_valid   <= 1'b0;
            r_state   <= S_IDLE;
          end
`endif
          else if (!r_preset_done && (r_preset == GATE_LAST)) begin
            r_preset_done <= 1'b1;
`ifdef GATE_CTRL_TIMEOUT_EN
            r_tcnt <= '0;
`endif
          end
`ifdef GATE_CTRL_TIMEOUT_EN
          else if (r_preset_done) begin
            r_tcnt <= r_tcnt + TW'(1);
          end
`endif
        end
        S_LATCH: begin
          r_cnt_latch <= 1'b1;
          r_state     <= S_FIN;
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_valid <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gate      = r_gate;
  assign cnt_clr   = r_cnt_clr;
  assign cnt_latch = r_cnt_latch;
  assign valid     = r_valid;
  assign done      = r_done;
  assign busy      = (r_state != S_IDLE);
`ifdef GATE_CTRL_TIMEOUT_EN
  assign timeout   = r_timeout;
`else
  assign timeout   = 1'b0;
  assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

endmodule
